// File: rtl/rename_stage_pkg.sv
// Shared constants and the renamed-instruction layout used by the rename stage
// and the issue queue.
package rename_stage_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int AREG_BITS     = 5;
    localparam int PREG_BITS     = 6;
    localparam int OPCODE_BITS   = 7;
    localparam int FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_PTR_BITS   = $clog2(FL_DEPTH);

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [PREG_BITS-1:0]   phys_rd;
        logic [PREG_BITS-1:0]   phys_rs1;
        logic [PREG_BITS-1:0]   phys_rs2;
        logic [31:0]            immediate;
    } renamed_instr_t;
endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical tags. Holds tags 32..63 after reset; pops
// from head on allocation and pushes returned tags at tail on commit.
module rename_free_list
    import rename_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pop,
    input  logic                 push,
    input  logic [PREG_BITS-1:0] push_preg,
    output logic [PREG_BITS-1:0] head_preg,
    output logic [PREG_BITS-1:0] count,
    output logic                 overflow_err
);
    logic [PREG_BITS-1:0]   mem [FL_DEPTH];
    logic [FL_PTR_BITS-1:0] head;
    logic [FL_PTR_BITS-1:0] tail;
    logic                   full;
    logic                   pop_ok;
    logic                   push_req;
    logic                   push_ok;

    assign full      = (count == PREG_BITS'(FL_DEPTH));
    assign pop_ok    = pop && (count != '0);
    // Tag 0 is the hard-wired zero register and never enters the list.
    assign push_req  = push && (push_preg != '0);
    // A simultaneous pop makes room, so a push at full is only rejected alone.
    assign push_ok   = push_req && (!full || pop_ok);
    assign head_preg = mem[head];

    // Pointer, storage, occupancy and sticky overflow update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= PREG_BITS'(FL_DEPTH + i);
            end
            head         <= '0;
            tail         <= '0;
            count        <= PREG_BITS'(FL_DEPTH);
            overflow_err <= 1'b0;
        end else begin
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            if (push_ok) begin
                mem[tail] <= push_preg;
                tail      <= tail + 1'b1;
            end
            if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end else if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end
            if (push_req && full && !pop_ok) begin
                overflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup, destination allocation from the free
// list, and a one-entry valid/ready output register feeding the issue queue.
module rename_stage
    import rename_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPCODE_BITS-1:0] in_opcode,
    input  logic [AREG_BITS-1:0]   in_rd,
    input  logic [AREG_BITS-1:0]   in_rs1,
    input  logic [AREG_BITS-1:0]   in_rs2,
    input  logic                   in_rd_write,
    input  logic [31:0]            in_immediate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPCODE_BITS-1:0] out_opcode,
    output logic [PREG_BITS-1:0]   out_phys_rd,
    output logic [PREG_BITS-1:0]   out_phys_rs1,
    output logic [PREG_BITS-1:0]   out_phys_rs2,
    output logic [PREG_BITS-1:0]   out_old_phys_rd,
    output logic [31:0]            out_immediate,
    input  logic                   commit_free_en,
    input  logic [PREG_BITS-1:0]   commit_free_preg,
    output logic [PREG_BITS-1:0]   free_count,
    output logic                   fl_overflow_err
);
    logic [PREG_BITS-1:0] rat [NUM_ARCH_REGS];
    renamed_instr_t       out_q;
    logic [PREG_BITS-1:0] old_q;
    logic                 valid_q;
    logic [PREG_BITS-1:0] fl_head_preg;
    logic [PREG_BITS-1:0] fl_count;
    logic                 needs_alloc;
    logic                 accept;
    logic                 alloc;

    assign needs_alloc = in_rd_write && (in_rd != '0);
    assign in_ready    = (!valid_q || out_ready) && (!needs_alloc || fl_count != '0);
    assign accept      = in_valid && in_ready;
    assign alloc       = accept && needs_alloc;

    rename_free_list u_free_list (
        .clk          (clk),
        .reset_n      (reset_n),
        .pop          (alloc),
        .push         (commit_free_en),
        .push_preg    (commit_free_preg),
        .head_preg    (fl_head_preg),
        .count        (fl_count),
        .overflow_err (fl_overflow_err)
    );

    // RAT: identity map after reset; rd remapped to the popped tag on allocation.
    // x0 never allocates, so rat[0] stays 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat[i] <= PREG_BITS'(i);
            end
        end else if (alloc) begin
            rat[in_rd] <= fl_head_preg;
        end
    end

    // Output register: load on accept (sources read pre-update), drop on handoff.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            old_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            out_q.opcode    <= in_opcode;
            out_q.phys_rd   <= needs_alloc ? fl_head_preg : '0;
            out_q.phys_rs1  <= rat[in_rs1];
            out_q.phys_rs2  <= rat[in_rs2];
            out_q.immediate <= in_immediate;
            old_q           <= needs_alloc ? rat[in_rd] : '0;
            valid_q         <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid       = valid_q;
    assign out_opcode      = out_q.opcode;
    assign out_phys_rd     = out_q.phys_rd;
    assign out_phys_rs1    = out_q.phys_rs1;
    assign out_phys_rs2    = out_q.phys_rs2;
    assign out_old_phys_rd = old_q;
    assign out_immediate   = out_q.immediate;
    assign free_count      = fl_count;
endmodule
